golomb_issue_arbiter: RTL

- Shares one exp_golomb_code instance between the DC-coefficient requester and the AC run/level requester of the ProRes VLC stage.
- Arbitrates between the two, drives the Golomb unit's input bus and tracks each request through the unit's fixed pipeline with a source tag.
- Buffers results in a small FIFO so the bit packer can apply backpressure, even though the Golomb unit cannot stall.
- Provides a flush/drain sequence for end-of-slice.

---
 rtl/golomb_issue_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/golomb_issue_arbiter.sv
// Shares one Golomb coder between the DC and AC requesters: round-robin issue, tag pipe, result FIFO.
// Optional issue counters are enabled with `define GOLOMB_ARB_STATS_EN.
`timescale 1ns/1ps
module golomb_issue_arbiter #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dc_valid,
    output logic        dc_ready,
    input  logic [31:0] dc_val,
    input  logic [2:0]  dc_k,
    input  logic        ac_valid,
    output logic        ac_ready,
    input  logic [31:0] ac_val,
    input  logic [2:0]  ac_k,
    input  logic        ac_is_level,
    input  logic        ac_minus,
    input  logic [1:0]  ac_setbit,
    output logic        eg_input_valid,
    output logic [31:0] eg_val,
    output logic [2:0]  eg_k,
    output logic        eg_is_ac_level,
    output logic        eg_is_ac_minus_n,
    output logic [1:0]  eg_is_add_setbit,
    input  logic        eg_output_valid,
    input  logic [31:0] eg_sum,
    input  logic [31:0] eg_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_code,
    output logic [31:0] out_len,
    output logic        out_src,
    input  logic        flush_req,
    output logic        flush_done,
    output logic        err
`ifdef GOLOMB_ARB_STATS_EN
    ,
    output logic [15:0] stat_dc_cnt,
    output logic [15:0] stat_ac_cnt
`endif
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW   = $clog2(FIFO_DEPTH + LATENCY + 1);
    localparam int unsigned LAST = LATENCY - 1;

    typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

    state_e               r_state, w_state_next;
    logic                 r_prio_ac;
    logic [LATENCY-1:0]   r_tag_v, r_tag_src;
    logic [64:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [CW-1:0]        r_count;
    logic                 r_err;

    logic [OW-1:0]        w_tag_cnt, w_occ;
    logic                 w_allow, w_pick_ac, w_pick_dc, w_issue;
    logic                 w_empty, w_full, w_pop, w_push, w_push_err, w_tag_err;
    logic [64:0]          w_head;

    always_comb begin
        w_tag_cnt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_tag_cnt = w_tag_cnt + OW'(r_tag_v[i]);
        end
    end

    // Credit counts results still inside the coder, so the FIFO can always absorb them.
    assign w_occ   = OW'(r_count) + w_tag_cnt;
    assign w_allow = (r_state == StRun) && (w_occ < OW'(FIFO_DEPTH));

    assign w_pick_ac = ac_valid && (!dc_valid || r_prio_ac);
    assign w_pick_dc = dc_valid && !w_pick_ac;
    assign dc_ready  = w_allow && w_pick_dc;
    assign ac_ready  = w_allow && w_pick_ac;
    assign w_issue   = dc_ready || ac_ready;

    assign eg_input_valid = w_issue;

    always_comb begin
        eg_val           = '0;
        eg_k             = '0;
        eg_is_ac_level   = 1'b0;
        eg_is_ac_minus_n = 1'b0;
        eg_is_add_setbit = '0;
        if (dc_ready) begin
            eg_val = dc_val;
            eg_k   = dc_k;
        end else if (ac_ready) begin
            eg_val           = ac_val;
            eg_k             = ac_k;
            eg_is_ac_level   = ac_is_level;
            eg_is_ac_minus_n = ac_minus;
            eg_is_add_setbit = ac_setbit;
        end
    end

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_pop      = !w_empty && out_ready;
    // A result without a tag is dropped; a full FIFO accepts only alongside a pop.
    assign w_push     = eg_output_valid && r_tag_v[LAST] && (!w_full || w_pop);
    assign w_push_err = eg_output_valid && r_tag_v[LAST] && w_full && !w_pop;
    assign w_tag_err  = (eg_output_valid != r_tag_v[LAST]);

    assign w_head    = r_mem[r_rptr];
    assign out_valid = !w_empty;
    assign out_code  = w_empty ? '0 : w_head[64:33];
    assign out_len   = w_empty ? '0 : w_head[32:1];
    assign out_src   = w_empty ? 1'b0 : w_head[0];
    assign err       = r_err;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StRun:   if (flush_req) w_state_next = StDrain;
            StDrain: if (w_occ == '0) w_state_next = StDone;
            StDone:  w_state_next = StRun;
            default: w_state_next = StRun;
        endcase
    end

    assign flush_done = (r_state == StDone);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {eg_sum, eg_len, r_tag_src[LAST]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StRun;
            r_prio_ac <= 1'b0;
            r_tag_v   <= '0;
            r_tag_src <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            if (w_issue) r_prio_ac <= dc_ready;
            r_tag_v[0]   <= w_issue;
            r_tag_src[0] <= ac_ready;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_src[i] <= r_tag_src[i-1];
            end
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_tag_err || w_push_err) r_err <= 1'b1;
        end
    end

`ifdef GOLOMB_ARB_STATS_EN
    logic [15:0] r_dc_cnt, r_ac_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dc_cnt <= '0;
            r_ac_cnt <= '0;
        end else if (flush_done) begin
            r_dc_cnt <= '0;
            r_ac_cnt <= '0;
        end else begin
            if (dc_ready && (r_dc_cnt != 16'hFFFF)) r_dc_cnt <= r_dc_cnt + 16'd1;
            if (ac_ready && (r_ac_cnt != 16'hFFFF)) r_ac_cnt <= r_ac_cnt + 16'd1;
        end
    end

    assign stat_dc_cnt = r_dc_cnt;
    assign stat_ac_cnt = r_ac_cnt;
`endif

endmodule
